axis_mux_arb: RTL and testbench
===============================

# axis_mux_arb

Packet-level arbiter that drives the `enable`/`select` control of the `axis_mux` AXI4-Stream multiplexer. It monitors the mux's input-side handshake signals (`tvalid`/`tready`/`tlast`) and grants the output to one input at a time. Arbitration is either fixed-priority or round-robin, with an optional multi-packet burst allowance per grant. It sits beside the mux in any N:1 stream-aggregation path, replacing hand-driven select logic.

## Interface
Parameters:
- `S_COUNT`, 4, number of requesting inputs (≥2)
- `ARB_ROUND_ROBIN`, 1, 1 = round-robin from rotating pointer; 0 = fixed priority, lowest index wins
- `BURST_PACKETS`, 1, maximum consecutive packets per grant while grantee keeps requesting (≥1)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_axis_tvalid`  in  S_COUNT  mux input valids; a valid bit is a request
- `s_axis_tready`  in  S_COUNT  mux input readies (monitor only)
- `s_axis_tlast`  in  S_COUNT  mux input lasts (monitor only)
- `arb_enable`  in  1  1 = new grants permitted; 0 = no new grant, current grant runs to completion
- `enable`  out  1  to mux `enable`
- `select`  out  $clog2(S_COUNT)  to mux `select`
- `grant`  out  S_COUNT  one-hot copy of current grant; 0 when idle
- `grant_valid`  out  1  grant active
- `pkt_count`  out  $clog2(BURST_PACKETS+1)  packets completed in current grant

## Operation
- States: IDLE, GRANT. All outputs registered.
- IDLE: if `arb_enable` and `s_axis_tvalid != 0`, choose winner W:
  - fixed priority: lowest set index;
  - round-robin: first set index at or above `ptr`, wrapping modulo S_COUNT.
  - Register `select`=W, `grant`=1<<W, `grant_valid`=1, `enable`=1, `pkt_count`=0; go to GRANT.
  - No request or `arb_enable`=0: stay in IDLE; outputs hold idle values.
- GRANT: `select` is frozen. A packet end is `s_axis_tvalid[select] & s_axis_tready[select] & s_axis_tlast[select]`.
  - Packet end with `pkt_count+1 < BURST_PACKETS`, `arb_enable`=1, and `s_axis_tvalid[select]` still high on the following cycle: increment `pkt_count`; stay in GRANT with `enable` held, so the mux relatches the same port.
  - Otherwise, on packet end: go to IDLE; clear `enable`, `grant`, `grant_valid`, `pkt_count`; set `ptr` = (select+1) mod S_COUNT.
  - Non-last beats and stalls do not change state.
- `ptr` updates only at grant release and is unused when `ARB_ROUND_ROBIN`=0.
- `arb_enable` deasserted during GRANT: the current packet completes, then the block releases regardless of remaining burst allowance.
- Every grant release passes through IDLE for at least one cycle with `enable`=0. This guarantees the mux frame latch is clear before `select` changes.
- `select` is never changed while `enable`=1.

## Timing
- Reset values: `enable`=0, `select`=0, `grant`=0, `grant_valid`=0, `pkt_count`=0, `ptr`=0, state IDLE.
- Reset asserted mid-packet: all outputs are at reset values on the next cycle. Mux reset is the system's responsibility.
- Request seen in IDLE at cycle N: `enable`/`grant` high from N+1.
- Packet end at cycle N on release: `enable`=0 at N+1; the earliest next grant is visible at N+2.
- Burst continuation: `enable` stays high with no gap; `pkt_count` increments at N+1.
- Simultaneous requests: exactly one grant; `grant` is always one-hot or zero.
- Wrap-around: with `ptr`=S_COUNT-1 and requests only at index 0, the winner is 0.

## Test plan
- Reset then single request `s_axis_tvalid`=4'b0100 → `grant`=4'b0100, `select`=2, `enable`=1 one cycle later; 3-beat packet ending with tlast → `enable`=0 the cycle after the tlast handshake.
- Round-robin, all four inputs continuously requesting, 1-beat packets, `BURST_PACKETS`=1 → grant order 0,1,2,3,0, with a one-cycle enable gap between grants.
- `ARB_ROUND_ROBIN`=0, `s_axis_tvalid`=4'b1010 held → port 1 granted every time; port 3 starved.
- `BURST_PACKETS`=3, port 2 sends 4 back-to-back packets while port 0 also requests → `pkt_count` 0,1,2; port 2 released after 3 packets; port 0 granted next.
- `arb_enable` dropped mid-packet on port 1 → packet completes, `enable`=0 afterward, no new grant until `arb_enable`=1.
- `rst` asserted mid-burst with `tready` stalled → next cycle all outputs zero; first request after reset is served from `ptr`=0.

Source files
------------

// File: rtl/axis_mux_arb.sv
// Packet-level N:1 arbiter driving axis_mux enable/select; registered outputs, grant one cycle after request.
// Monitors tvalid/tready/tlast only (never stalls the stream); every release idles one cycle with enable low.
module axis_mux_arb #(
    parameter int S_COUNT         = 4,
    parameter int ARB_ROUND_ROBIN = 1,
    parameter int BURST_PACKETS   = 1,
    localparam int SEL_W          = $clog2(S_COUNT),
    localparam int CNT_W          = $clog2(BURST_PACKETS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_COUNT-1:0] s_axis_tvalid,
    input  logic [S_COUNT-1:0] s_axis_tready,
    input  logic [S_COUNT-1:0] s_axis_tlast,
    input  logic               arb_enable,
    output logic               enable,
    output logic [SEL_W-1:0]   select,
    output logic [S_COUNT-1:0] grant,
    output logic               grant_valid,
    output logic [CNT_W-1:0]   pkt_count
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [S_COUNT-1:0] grant_q, grant_d;
    logic               active_q, active_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               chk_q, chk_d;

    logic [SEL_W-1:0]   win;
    logic               found;
    logic               sel_vld;
    logic               pkt_end;
    logic               burst_ok;

    // Search order starts at ptr for round-robin, at 0 for fixed priority.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (ARB_ROUND_ROBIN != 0) begin
                idx = (int'(ptr_q) + i) % S_COUNT;
            end else begin
                idx = i;
            end
            if (!found && s_axis_tvalid[idx]) begin
                win   = SEL_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign sel_vld  = s_axis_tvalid[sel_q];
    assign pkt_end  = sel_vld & s_axis_tready[sel_q] & s_axis_tlast[sel_q];
    assign burst_ok = ((int'(pkt_q) + 1) < BURST_PACKETS) && arb_enable;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        active_d = active_q;
        pkt_d    = pkt_q;
        ptr_d    = ptr_q;
        chk_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_enable && found) begin
                    state_d  = GRANT;
                    sel_d    = win;
                    grant_d  = {{(S_COUNT-1){1'b0}}, 1'b1} << win;
                    active_d = 1'b1;
                    pkt_d    = '0;
                end
            end
            GRANT: begin
                // chk_q marks the cycle after a burst continuation: the grantee
                // must still be requesting there, otherwise the grant is dropped.
                if ((chk_q && !sel_vld) || (pkt_end && !burst_ok)) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    active_d = 1'b0;
                    pkt_d    = '0;
                    ptr_d    = (int'(sel_q) == S_COUNT - 1) ? '0 : sel_q + SEL_W'(1);
                end else if (pkt_end) begin
                    pkt_d = pkt_q + CNT_W'(1);
                    chk_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                active_d = 1'b0;
                pkt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            grant_q  <= '0;
            active_q <= 1'b0;
            pkt_q    <= '0;
            ptr_q    <= '0;
            chk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            pkt_q    <= pkt_d;
            ptr_q    <= ptr_d;
            chk_q    <= chk_d;
        end
    end

    assign enable      = active_q;
    assign grant_valid = active_q;
    assign select      = sel_q;
    assign grant       = grant_q;
    assign pkt_count   = pkt_q;

endmodule

// File: tb/tb_axis_mux_arb.sv
// Directed bench for axis_mux_arb: three configurations share one stimulus stream,
// each step checks only the instance whose configuration it targets.
module tb_axis_mux_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arb_en = 1'b1;
    logic [3:0] tv = 4'b0000;
    logic [3:0] tr = 4'b0000;
    logic [3:0] tl = 4'b0000;

    int n_checks = 0;
    int n_fail   = 0;

    // round-robin, burst 1
    logic       en_rr1, gv_rr1;
    logic [1:0] sel_rr1;
    logic [3:0] gnt_rr1;
    logic [0:0] pc_rr1;
    // fixed priority, burst 1
    logic       en_fp, gv_fp;
    logic [1:0] sel_fp;
    logic [3:0] gnt_fp;
    logic [0:0] pc_fp;
    // round-robin, burst 3
    logic       en_rr3, gv_rr3;
    logic [1:0] sel_rr3;
    logic [3:0] gnt_rr3;
    logic [1:0] pc_rr3;

    axis_mux_arb #(.S_COUNT(4), .ARB_ROUND_ROBIN(1), .BURST_PACKETS(1)) u_rr1 (
        .clk(clk), .rst(rst), .s_axis_tvalid(tv), .s_axis_tready(tr), .s_axis_tlast(tl),
        .arb_enable(arb_en), .enable(en_rr1), .select(sel_rr1), .grant(gnt_rr1),
        .grant_valid(gv_rr1), .pkt_count(pc_rr1));

    axis_mux_arb #(.S_COUNT(4), .ARB_ROUND_ROBIN(0), .BURST_PACKETS(1)) u_fp (
        .clk(clk), .rst(rst), .s_axis_tvalid(tv), .s_axis_tready(tr), .s_axis_tlast(tl),
        .arb_enable(arb_en), .enable(en_fp), .select(sel_fp), .grant(gnt_fp),
        .grant_valid(gv_fp), .pkt_count(pc_fp));

    axis_mux_arb #(.S_COUNT(4), .ARB_ROUND_ROBIN(1), .BURST_PACKETS(3)) u_rr3 (
        .clk(clk), .rst(rst), .s_axis_tvalid(tv), .s_axis_tready(tr), .s_axis_tlast(tl),
        .arb_enable(arb_en), .enable(en_rr3), .select(sel_rr3), .grant(gnt_rr3),
        .grant_valid(gv_rr3), .pkt_count(pc_rr3));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        arb_en = 1'b1;
        tv     = 4'b0000;
        tr     = 4'b0000;
        tl     = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state and single request on port 2 with a 3-beat packet
        do_reset();
        chk("rst_enable", 32'(en_rr1), 0);
        chk("rst_select", 32'(sel_rr1), 0);
        chk("rst_grant", 32'(gnt_rr1), 0);
        chk("rst_gvalid", 32'(gv_rr1), 0);
        chk("rst_pktcnt", 32'(pc_rr3), 0);
        tv = 4'b0100;
        tick();
        chk("single_grant", 32'(gnt_rr1), 'h4);
        chk("single_select", 32'(sel_rr1), 2);
        chk("single_enable", 32'(en_rr1), 1);
        chk("single_gvalid", 32'(gv_rr1), 1);
        tr = 4'b0100;
        tick();
        tick();
        chk("single_midpkt_enable", 32'(en_rr1), 1);
        tl = 4'b0100;
        tick();
        chk("single_release_enable", 32'(en_rr1), 0);
        chk("single_release_grant", 32'(gnt_rr1), 0);
        tv = 4'b0000; tr = 4'b0000; tl = 4'b0000;
        tick();
        chk("single_idle_enable", 32'(en_rr1), 0);

        // Round-robin, all ports requesting with 1-beat packets
        do_reset();
        tv = 4'b1111; tr = 4'b1111; tl = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_grant", 32'(gnt_rr1), 32'(1) << (k % 4));
            chk("rr_enable", 32'(en_rr1), 1);
            tick();
            chk("rr_gap_enable", 32'(en_rr1), 0);
        end

        // Fixed priority: port 1 always wins over port 3
        do_reset();
        tv = 4'b1010; tr = 4'b1010; tl = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fp_grant", 32'(gnt_fp), 'h2);
            chk("fp_select", 32'(sel_fp), 1);
            tick();
            chk("fp_gap_grant", 32'(gnt_fp), 0);
        end

        // Burst of 3 on port 2 with port 0 waiting, then wrap-around to port 0
        do_reset();
        tv = 4'b0100;
        tick();
        chk("burst_grant", 32'(gnt_rr3), 'h4);
        chk("burst_pkt0", 32'(pc_rr3), 0);
        tv = 4'b0101; tr = 4'b0100; tl = 4'b0100;
        tick();
        chk("burst_pkt1", 32'(pc_rr3), 1);
        chk("burst_enable1", 32'(en_rr3), 1);
        tick();
        chk("burst_pkt2", 32'(pc_rr3), 2);
        chk("burst_grant2", 32'(gnt_rr3), 'h4);
        tick();
        chk("burst_release_enable", 32'(en_rr3), 0);
        chk("burst_release_pkt", 32'(pc_rr3), 0);
        chk("burst_release_grant", 32'(gnt_rr3), 0);
        tr = 4'b0000; tl = 4'b0000;
        tick();
        chk("wrap_grant", 32'(gnt_rr3), 'h1);
        chk("wrap_select", 32'(sel_rr3), 0);

        // arb_enable dropped mid-packet on port 1
        do_reset();
        tv = 4'b0010;
        tick();
        chk("arben_grant", 32'(gnt_rr1), 'h2);
        tr = 4'b0010;
        tick();
        arb_en = 1'b0;
        tick();
        chk("arben_midpkt_enable", 32'(en_rr1), 1);
        tl = 4'b0010;
        tick();
        chk("arben_release_enable", 32'(en_rr1), 0);
        tr = 4'b0000; tl = 4'b0000;
        tick();
        tick();
        chk("arben_held_grant", 32'(gnt_rr1), 0);
        chk("arben_held_enable", 32'(en_rr1), 0);
        arb_en = 1'b1;
        tick();
        chk("arben_regrant", 32'(gnt_rr1), 'h2);

        // Burst dropped when grantee stops requesting, then reset mid-burst
        do_reset();
        tv = 4'b0010;
        tick();
        tr = 4'b0010; tl = 4'b0010;
        tick();
        chk("drop_pkt1", 32'(pc_rr3), 1);
        tv = 4'b0000; tr = 4'b0000; tl = 4'b0000;
        tick();
        chk("drop_release_enable", 32'(en_rr3), 0);
        chk("drop_release_pkt", 32'(pc_rr3), 0);
        tv = 4'b1000;
        tick();
        chk("midrst_grant", 32'(gnt_rr3), 'h8);
        tr = 4'b1000; tl = 4'b1000;
        tick();
        tr = 4'b0000; tl = 4'b0000;
        tick();
        chk("midrst_stall_enable", 32'(en_rr3), 1);
        chk("midrst_stall_pkt", 32'(pc_rr3), 1);
        rst = 1'b1;
        tick();
        chk("midrst_enable", 32'(en_rr3), 0);
        chk("midrst_select", 32'(sel_rr3), 0);
        chk("midrst_grant0", 32'(gnt_rr3), 0);
        chk("midrst_gvalid", 32'(gv_rr3), 0);
        chk("midrst_pkt", 32'(pc_rr3), 0);
        rst = 1'b0;
        tv = 4'b1010;
        tick();
        chk("postrst_grant", 32'(gnt_rr3), 'h2);
        chk("postrst_select", 32'(sel_rr3), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
